pipe_ctrl: RTL and testbench

Pipeline hazard controller for the 5-stage core. It drives hold and flush controls for the PC register, the IF/ID register and the ID/EX register, and a hold for the EX stage. It detects load-use hazards, flushes the two front stages on a taken branch or jump resolved in EX, and stalls the whole front end for a fixed number of cycles while the multi-cycle mul/div unit works. It also keeps a free-running stall-cycle performance counter.

---
 rtl/pipe_ctrl_pkg.sv | 26 ++
 rtl/pipe_stall_timer.sv | 28 ++
 rtl/pipe_ctrl.sv | 119 +++++++++++
 tb/tb_pipe_ctrl.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared core definitions for the pipeline hazard controller: state encoding,
// register-index width, the canonical nop and the control-output bundle.
package pipe_ctrl_pkg;

  localparam int unsigned REG_IDX_W   = 5;
  localparam int unsigned CNT_W       = 8;
  localparam int unsigned STALL_CNT_W = 32;

  // addi x0, x0, 0
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic {
    RUN     = 1'b0,
    MD_BUSY = 1'b1
  } state_e;

  typedef struct packed {
    logic pc_hold;
    logic if_id_hold;
    logic if_id_flush;
    logic id_ex_flush;
    logic ex_hold;
    logic md_done;
  } ctl_t;

endpackage

// File: rtl/pipe_stall_timer.sv
// Loadable down-counter that times a mul/div occupancy of EX; flags the
// final cycle when the count reaches one.
module pipe_stall_timer
  import pipe_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_last_c
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_last_c = (r_cnt == CNT_W'(1));

endmodule

// File: rtl/pipe_ctrl.sv
// Hazard controller for the 5-stage core: load-use bubbles, EX-resolved
// jump flushes, multi-cycle mul/div front-end stall and a stall-cycle counter.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MD_LAT = 34
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [REG_IDX_W-1:0]   id_rs1,
  input  logic [REG_IDX_W-1:0]   id_rs2,
  input  logic                   id_rs1_re,
  input  logic                   id_rs2_re,
  input  logic [REG_IDX_W-1:0]   ex_rd,
  input  logic                   ex_is_load,
  input  logic                   ex_jump,
  input  logic                   ex_md_start,
  output logic                   pc_hold,
  output logic                   if_id_hold,
  output logic                   if_id_flush,
  output logic                   id_ex_flush,
  output logic                   ex_hold,
  output logic                   md_done,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  localparam logic [CNT_W-1:0] MD_LOAD = CNT_W'(MD_LAT - 1);

  state_e                 r_state;
  state_e                 w_state_nxt;
  ctl_t                   w_ctl;
  logic                   w_load_use;
  logic                   w_tmr_load;
  logic                   w_tmr_dec;
  logic                   w_tmr_last;
  logic [STALL_CNT_W-1:0] r_stall_cnt;

  // x0 is hard-wired zero, so a load targeting it never creates a dependency
  assign w_load_use = ex_is_load && (ex_rd != '0) &&
                      ((id_rs1_re && (id_rs1 == ex_rd)) ||
                       (id_rs2_re && (id_rs2 == ex_rd)));

  pipe_stall_timer u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_tmr_load),
    .i_load_val (MD_LOAD),
    .i_dec      (w_tmr_dec),
    .o_last_c   (w_tmr_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Priority: jump > mul/div > load-use; MD_BUSY ignores every request
  always_comb begin
    w_state_nxt = r_state;
    w_ctl       = '0;
    w_tmr_load  = 1'b0;
    w_tmr_dec   = 1'b0;
    case (r_state)
      RUN: begin
        if (ex_jump) begin
          w_ctl.if_id_flush = 1'b1;
          w_ctl.id_ex_flush = 1'b1;
        end else if (ex_md_start) begin
          w_ctl.pc_hold    = 1'b1;
          w_ctl.if_id_hold = 1'b1;
          w_ctl.ex_hold    = 1'b1;
          w_tmr_load       = 1'b1;
          w_state_nxt      = MD_BUSY;
        end else if (w_load_use) begin
          w_ctl.pc_hold     = 1'b1;
          w_ctl.if_id_hold  = 1'b1;
          w_ctl.id_ex_flush = 1'b1;
        end
      end
      MD_BUSY: begin
        w_ctl.pc_hold    = 1'b1;
        w_ctl.if_id_hold = 1'b1;
        w_ctl.ex_hold    = 1'b1;
        w_tmr_dec        = 1'b1;
        if (w_tmr_last) begin
          w_ctl.md_done = 1'b1;
          w_state_nxt   = RUN;
        end
      end
      default: w_state_nxt = RUN;
    endcase
    if (w_ctl.if_id_flush) begin
      w_ctl.if_id_hold = 1'b0;
    end
    if (!rst_n) begin
      w_ctl = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (w_ctl.pc_hold) begin
      r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
    end
  end

  assign pc_hold     = w_ctl.pc_hold;
  assign if_id_hold  = w_ctl.if_id_hold;
  assign if_id_flush = w_ctl.if_id_flush;
  assign id_ex_flush = w_ctl.id_ex_flush;
  assign ex_hold     = w_ctl.ex_hold;
  assign md_done     = w_ctl.md_done;
  assign stall_cnt   = r_stall_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus randomized
// traffic compared against a cycle-level behavioural model.
module tb_pipe_ctrl;

  localparam int unsigned MD_LAT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_rs1_re, id_rs2_re, ex_is_load, ex_jump, ex_md_start;
  logic        pc_hold, if_id_hold, if_id_flush, id_ex_flush, ex_hold, md_done;
  logic [31:0] stall_cnt;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          m_md_left;
  logic [31:0] m_stall;

  pipe_ctrl #(.MD_LAT(MD_LAT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_rs1_re   (id_rs1_re),
    .id_rs2_re   (id_rs2_re),
    .ex_rd       (ex_rd),
    .ex_is_load  (ex_is_load),
    .ex_jump     (ex_jump),
    .ex_md_start (ex_md_start),
    .pc_hold     (pc_hold),
    .if_id_hold  (if_id_hold),
    .if_id_flush (if_id_flush),
    .id_ex_flush (id_ex_flush),
    .ex_hold     (ex_hold),
    .md_done     (md_done),
    .stall_cnt   (stall_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got no finish want finish");
    $fatal(1, "watchdog");
  end

  // {pc_hold, if_id_hold, if_id_flush, id_ex_flush, ex_hold, md_done}
  function automatic logic [5:0] dut_ctl();
    return {pc_hold, if_id_hold, if_id_flush, id_ex_flush, ex_hold, md_done};
  endfunction

  // Reference: m_md_left counts remaining mul/div cycles after the start cycle
  function automatic logic [5:0] model_ctl();
    bit lu;
    if (!rst_n) return 6'b000000;
    if (m_md_left > 0) return (m_md_left == 1) ? 6'b110011 : 6'b110010;
    if (ex_jump) return 6'b001100;
    if (ex_md_start) return 6'b110010;
    lu = 1'b0;
    if (ex_is_load && ex_rd != 5'd0) begin
      if (id_rs1_re && id_rs1 == ex_rd) lu = 1'b1;
      if (id_rs2_re && id_rs2 == ex_rd) lu = 1'b1;
    end
    return lu ? 6'b110100 : 6'b000000;
  endfunction

  task automatic model_tick();
    logic [5:0] e;
    if (!rst_n) begin
      m_md_left = 0;
      m_stall   = 32'd0;
    end else begin
      e = model_ctl();
      if (e[5]) m_stall = m_stall + 32'd1;
      if (m_md_left > 0) m_md_left = m_md_left - 1;
      else if (!ex_jump && ex_md_start) m_md_left = MD_LAT - 1;
    end
  endtask

  task automatic advance();
    @(posedge clk);
    model_tick();
    #1;
  endtask

  task automatic idle();
    id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
    id_rs1_re = 1'b0; id_rs2_re = 1'b0; ex_is_load = 1'b0;
    ex_jump = 1'b0; ex_md_start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ex_is_load = 1'b1; ex_rd = 5'd9; id_rs1 = 5'd9; id_rs1_re = 1'b1;
      ex_md_start = 1'($urandom_range(0, 1)); ex_jump = 1'($urandom_range(0, 1));
      @(negedge clk);
      n_checks++;
      if (dut_ctl() !== 6'b000000) begin
        n_fail++; $display("FAIL reset_ctl: got %b want %b", dut_ctl(), 6'b000000);
      end
      n_checks++;
      if (stall_cnt !== 32'd0) begin
        n_fail++; $display("FAIL reset_stall: got %0d want 0", stall_cnt);
      end
      advance();
    end
    rst_n = 1'b1;
    idle();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (dut_ctl() !== 6'b000000 || stall_cnt !== 32'd0) begin
        n_fail++; $display("FAIL idle_after_reset: got ctl %b cnt %0d want 000000 cnt 0", dut_ctl(), stall_cnt);
      end
      advance();
    end
  endtask

  task automatic test_load_use();
    idle();
    ex_is_load = 1'b1; ex_rd = 5'd5; id_rs2_re = 1'b1; id_rs2 = 5'd5;
    id_rs1_re = 1'b1; id_rs1 = 5'd3;
    @(negedge clk);
    n_checks++;
    if (dut_ctl() !== 6'b110100) begin
      n_fail++; $display("FAIL load_use_hit: got %b want %b", dut_ctl(), 6'b110100);
    end
    advance();
    idle();
    @(negedge clk);
    n_checks++;
    if (dut_ctl() !== 6'b000000 || stall_cnt !== 32'd1) begin
      n_fail++; $display("FAIL load_use_clear: got ctl %b cnt %0d want 000000 cnt 1", dut_ctl(), stall_cnt);
    end
    advance();
    ex_is_load = 1'b1; ex_rd = 5'd0; id_rs2_re = 1'b1; id_rs2 = 5'd0;
    id_rs1_re = 1'b1; id_rs1 = 5'd0;
    @(negedge clk);
    n_checks++;
    if (dut_ctl() !== 6'b000000) begin
      n_fail++; $display("FAIL load_use_x0: got %b want %b", dut_ctl(), 6'b000000);
    end
    advance();
    ex_rd = 5'd7; id_rs1 = 5'd7; id_rs1_re = 1'b0; id_rs2 = 5'd7; id_rs2_re = 1'b0;
    @(negedge clk);
    n_checks++;
    if (dut_ctl() !== 6'b000000) begin
      n_fail++; $display("FAIL load_use_no_read: got %b want %b", dut_ctl(), 6'b000000);
    end
    advance();
    idle();
    @(negedge clk);
    n_checks++;
    if (stall_cnt !== 32'd1) begin
      n_fail++; $display("FAIL load_use_stall_cnt: got %0d want 1", stall_cnt);
    end
    advance();
  endtask

  task automatic test_jump();
    logic [31:0] s0;
    idle();
    s0 = m_stall;
    ex_jump = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd12; id_rs1_re = 1'b1; id_rs1 = 5'd12;
    @(negedge clk);
    n_checks++;
    if (dut_ctl() !== 6'b001100) begin
      n_fail++; $display("FAIL jump_over_load_use: got %b want %b", dut_ctl(), 6'b001100);
    end
    advance();
    idle();
    ex_jump = 1'b1; ex_md_start = 1'b1;
    @(negedge clk);
    n_checks++;
    if (dut_ctl() !== 6'b001100) begin
      n_fail++; $display("FAIL jump_over_md: got %b want %b", dut_ctl(), 6'b001100);
    end
    advance();
    idle();
    @(negedge clk);
    n_checks++;
    if (dut_ctl() !== 6'b000000 || stall_cnt !== s0) begin
      n_fail++; $display("FAIL jump_after: got ctl %b cnt %0d want 000000 cnt %0d", dut_ctl(), stall_cnt, s0);
    end
    advance();
  endtask

  task automatic test_mul_div();
    logic [31:0] s0;
    logic [5:0]  exp;
    idle();
    s0 = m_stall;
    for (int k = 0; k < MD_LAT + 1; k++) begin
      idle();
      ex_md_start = (k < MD_LAT);
      ex_jump     = (k == 1);
      if (k == 2) begin
        ex_is_load = 1'b1; ex_rd = 5'd4; id_rs1_re = 1'b1; id_rs1 = 5'd4;
      end
      exp = (k < MD_LAT - 1) ? 6'b110010 : (k == MD_LAT - 1) ? 6'b110011 : 6'b000000;
      @(negedge clk);
      n_checks++;
      if (dut_ctl() !== exp) begin
        n_fail++; $display("FAIL mul_div_cycle%0d: got %b want %b", k, dut_ctl(), exp);
      end
      advance();
    end
    idle();
    @(negedge clk);
    n_checks++;
    if (stall_cnt !== s0 + 32'd4) begin
      n_fail++; $display("FAIL mul_div_stall_cnt: got %0d want %0d", stall_cnt, s0 + 32'd4);
    end
    advance();
  endtask

  task automatic test_back_to_back();
    int dones = 0;
    for (int k = 0; k < 2 * MD_LAT + 3; k++) begin
      idle();
      ex_md_start = (k < MD_LAT) || (k > MD_LAT && k <= 2 * MD_LAT);
      @(negedge clk);
      n_checks++;
      if (dut_ctl() !== model_ctl()) begin
        n_fail++; $display("FAIL b2b_cycle%0d: got %b want %b", k, dut_ctl(), model_ctl());
      end
      if (md_done === 1'b1) dones++;
      advance();
    end
    n_checks++;
    if (dones != 2) begin
      n_fail++; $display("FAIL b2b_md_done_count: got %0d want 2", dones);
    end
  endtask

  task automatic test_reset_mid_md();
    idle();
    ex_md_start = 1'b1;
    advance();
    advance();
    @(negedge clk);
    n_checks++;
    if (dut_ctl() !== 6'b110010) begin
      n_fail++; $display("FAIL rst_mid_before: got %b want %b", dut_ctl(), 6'b110010);
    end
    advance();
    rst_n = 1'b0;
    ex_md_start = 1'b0;
    #1;
    n_checks++;
    if (dut_ctl() !== 6'b000000 || stall_cnt !== 32'd0) begin
      n_fail++; $display("FAIL rst_mid_abort: got ctl %b cnt %0d want 000000 cnt 0", dut_ctl(), stall_cnt);
    end
    advance();
    advance();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (dut_ctl() !== 6'b000000 || stall_cnt !== 32'd0) begin
        n_fail++; $display("FAIL rst_mid_after%0d: got ctl %b cnt %0d want 000000 cnt 0", i, dut_ctl(), stall_cnt);
      end
      advance();
    end
  endtask

  task automatic test_wrap();
    idle();
    ex_is_load = 1'b1; ex_rd = 5'd8; id_rs2_re = 1'b1; id_rs2 = 5'd8;
    @(negedge clk);
    force dut.r_stall_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.r_stall_cnt;
    m_stall = 32'hFFFF_FFFE;
    advance();
    @(negedge clk);
    n_checks++;
    if (stall_cnt !== 32'hFFFF_FFFF) begin
      n_fail++; $display("FAIL wrap_max: got %h want %h", stall_cnt, 32'hFFFF_FFFF);
    end
    advance();
    idle();
    @(negedge clk);
    n_checks++;
    if (stall_cnt !== 32'h0000_0000) begin
      n_fail++; $display("FAIL wrap_zero: got %h want %h", stall_cnt, 32'h0000_0000);
    end
    advance();
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      rst_n       = ($urandom_range(0, 59) != 0);
      ex_rd       = 5'($urandom_range(0, 7));
      id_rs1      = 5'($urandom_range(0, 7));
      id_rs2      = 5'($urandom_range(0, 7));
      id_rs1_re   = 1'($urandom_range(0, 1));
      id_rs2_re   = 1'($urandom_range(0, 1));
      ex_is_load  = 1'($urandom_range(0, 1));
      ex_jump     = ($urandom_range(0, 7) == 0);
      ex_md_start = ($urandom_range(0, 5) == 0);
      if (!rst_n) begin
        m_md_left = 0;
        m_stall   = 32'd0;
      end
      @(negedge clk);
      n_checks++;
      if (dut_ctl() !== model_ctl()) begin
        n_fail++; $display("FAIL rand_ctl%0d: got %b want %b", k, dut_ctl(), model_ctl());
      end
      n_checks++;
      if (stall_cnt !== m_stall) begin
        n_fail++; $display("FAIL rand_stall%0d: got %0d want %0d", k, stall_cnt, m_stall);
      end
      n_checks++;
      if (if_id_flush === 1'b1 && if_id_hold === 1'b1) begin
        n_fail++; $display("FAIL rand_flush_hold%0d: got both 1 want exclusive", k);
      end
      advance();
    end
    rst_n = 1'b1;
    idle();
  endtask

  initial begin
    m_md_left = 0;
    m_stall   = 32'd0;
    rst_n     = 1'b0;
    idle();
    #1;
    test_reset();
    test_load_use();
    test_jump();
    test_mul_div();
    test_back_to_back();
    test_reset_mid_md();
    test_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
